// File: rtl/ram_arb_pkg.sv
// Shared constants and helpers for the RAM port arbiter.
// RAM geometry and pointer sizing.
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_DEPTH  = 32;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with one-hot grant.
// Pointer moves past the winner only when advance is high.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);

  localparam int PTR_W = ptr_w(NUM_REQ);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  function automatic logic [PTR_W-1:0] wrap(input int v);
    return PTR_W'(v % NUM_REQ);
  endfunction

  // Scan from the pointer, wrapping; first active request wins.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    ptr_d = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && req[wrap(int'(ptr_q) + k)]) begin
        gnt[wrap(int'(ptr_q) + k)] = 1'b1;
        valid = 1'b1;
        ptr_d = wrap(int'(ptr_q) + k + 1);
      end
    end
  end

  // Pointer register; holds when nothing is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (advance && valid) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one 1R1W synchronous RAM between several kernels.
// Read and write ports arbitrate independently; RAW hazards stall the read.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = RAM_ADDR_W,
  parameter int DATA_W  = RAM_DATA_W,
  parameter int STALL_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_ren,
  input  logic [NUM_REQ*ADDR_W-1:0] req_raddr,
  input  logic [NUM_REQ-1:0]        req_wen,
  input  logic [NUM_REQ*ADDR_W-1:0] req_waddr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rgnt,
  output logic [NUM_REQ-1:0]        wgnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata_out,
  output logic [ADDR_W-1:0]         ram_raddr,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic                      ram_wen,
  output logic [ADDR_W-1:0]         ram_waddr,
  output logic [DATA_W-1:0]         ram_wdata,
  output logic [STALL_W-1:0]        stall_cnt
);

  logic [NUM_REQ-1:0] r_gnt_raw;
  logic [NUM_REQ-1:0] w_gnt_raw;
  logic               r_valid;
  logic               w_valid;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;
  logic               hazard;
  logic [NUM_REQ-1:0] ret_q;
  logic [STALL_W-1:0] stall_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_ren),
    .advance (!hazard),
    .gnt     (r_gnt_raw),
    .valid   (r_valid)
  );

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_wen),
    .advance (1'b1),
    .gnt     (w_gnt_raw),
    .valid   (w_valid)
  );

  // One-hot AND-OR muxes selecting the winners' slices.
  always_comb begin
    r_addr = '0;
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt_raw[i]) begin
        r_addr = r_addr | req_raddr[i*ADDR_W +: ADDR_W];
      end
      if (w_gnt_raw[i]) begin
        w_addr = w_addr | req_waddr[i*ADDR_W +: ADDR_W];
        w_data = w_data | req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // A read hitting the address being written this cycle waits a cycle.
  assign hazard = r_valid && w_valid && (r_addr == w_addr);

  assign rgnt      = (rst && !hazard) ? r_gnt_raw : '0;
  assign wgnt      = rst ? w_gnt_raw : '0;
  assign ram_wen   = rst && w_valid;
  assign ram_raddr = rst ? r_addr : '0;
  assign ram_waddr = rst ? w_addr : '0;
  assign ram_wdata = rst ? w_data : '0;
  assign rdata_out = ram_rdata;
  assign rvalid    = ret_q;
  assign stall_cnt = stall_q;

  // Return register tracks who owns the RAM data next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_q <= '0;
    end else begin
      ret_q <= rgnt;
    end
  end

  // Saturating hazard-stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (hazard && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 32x32 RAM.
// Small STALL_W build so saturation is reachable.
module tb_ram_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_ren;
  logic [N*AW-1:0] req_raddr;
  logic [N-1:0]    req_wen;
  logic [N*AW-1:0] req_waddr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rgnt;
  logic [N-1:0]    wgnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata_out;
  logic [AW-1:0]   ram_raddr;
  logic [DW-1:0]   ram_rdata = '0;
  logic            ram_wen;
  logic [AW-1:0]   ram_waddr;
  logic [DW-1:0]   ram_wdata;
  logic [SW-1:0]   stall_cnt;

  logic [DW-1:0] mem [0:31];

  int checks   = 0;
  int failures = 0;

  ram_port_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .STALL_W (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_ren   (req_ren),
    .req_raddr (req_raddr),
    .req_wen   (req_wen),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .rgnt      (rgnt),
    .wgnt      (wgnt),
    .rvalid    (rvalid),
    .rdata_out (rdata_out),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .ram_wen   (ram_wen),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_raddr];
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_ren = '0;
    req_wen = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    req_ren   = '1;
    req_wen   = '1;
    req_raddr = {5'd2, 5'd1};
    req_waddr = {5'd4, 5'd3};
    req_wdata = '1;

    // reset with every request asserted
    #12;
    check("rst_rgnt", rgnt, 0);
    check("rst_wgnt", wgnt, 0);
    check("rst_wen", ram_wen, 0);
    check("rst_raddr", ram_raddr, 0);
    check("rst_waddr", ram_waddr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_stall", stall_cnt, 0);

    cyc(); idle(); rst = 1'b1; #1;
    check("idle_rgnt", rgnt, 0);
    check("idle_wgnt", wgnt, 0);
    check("idle_wen", ram_wen, 0);
    check("idle_wdata", ram_wdata, 0);

    // T1: write 5 to addr 0, read it back
    cyc();
    req_wen = 2'b01; req_waddr[4:0] = 5'd0; req_wdata[31:0] = 32'd5;
    #1;
    check("t1_wgnt", wgnt, 2'b01);
    check("t1_wen", ram_wen, 1);
    check("t1_waddr", ram_waddr, 0);
    check("t1_wdata", ram_wdata, 5);
    cyc(); idle(); #1;
    check("t1_wen_off", ram_wen, 0);
    cyc();
    req_ren = 2'b01; req_raddr[4:0] = 5'd0;
    #1;
    check("t1_rgnt", rgnt, 2'b01);
    check("t1_raddr", ram_raddr, 0);
    check("t1_rv_early", rvalid, 0);
    cyc(); idle(); #1;
    check("t1_rvalid", rvalid, 2'b01);
    check("t1_rdata", rdata_out, 5);
    cyc(); #1;
    check("t1_rv_off", rvalid, 0);

    // T2 setup: mem[3]=33, mem[7]=77, then reset pointers
    cyc();
    req_wen = 2'b01; req_waddr[4:0] = 5'd3; req_wdata[31:0] = 32'h33;
    cyc();
    req_wen = 2'b10; req_waddr[9:5] = 5'd7; req_wdata[63:32] = 32'h77;
    cyc(); idle(); rst = 1'b0;
    cyc(); rst = 1'b1;

    // T2: both read continuously
    cyc();
    req_ren = 2'b11; req_raddr = {5'd7, 5'd3};
    #1;
    check("t2_g0", rgnt, 2'b01);
    check("t2_a0", ram_raddr, 3);
    cyc(); #1;
    check("t2_g1", rgnt, 2'b10);
    check("t2_a1", ram_raddr, 7);
    check("t2_v1", rvalid, 2'b01);
    check("t2_d1", rdata_out, 32'h33);
    cyc(); #1;
    check("t2_g2", rgnt, 2'b01);
    check("t2_v2", rvalid, 2'b10);
    check("t2_d2", rdata_out, 32'h77);
    cyc(); #1;
    check("t2_g3", rgnt, 2'b10);
    check("t2_v3", rvalid, 2'b01);
    check("t2_d3", rdata_out, 32'h33);
    cyc(); idle(); #1;
    check("t2_v4", rvalid, 2'b10);
    check("t2_d4", rdata_out, 32'h77);
    cyc(); #1;
    check("t2_v5", rvalid, 0);

    // T3: same-cycle write/read to addr 4
    cyc();
    req_wen = 2'b01; req_waddr[4:0] = 5'd4; req_wdata[31:0] = 32'hA5;
    req_ren = 2'b10; req_raddr[9:5] = 5'd4;
    #1;
    check("t3_wgnt", wgnt, 2'b01);
    check("t3_wen", ram_wen, 1);
    check("t3_rgnt_stall", rgnt, 0);
    check("t3_raddr", ram_raddr, 4);
    check("t3_stall0", stall_cnt, 0);
    cyc(); req_wen = '0; #1;
    check("t3_stall1", stall_cnt, 1);
    check("t3_rgnt", rgnt, 2'b10);
    check("t3_wgnt_off", wgnt, 0);
    cyc(); idle(); #1;
    check("t3_rvalid", rvalid, 2'b10);
    check("t3_rdata", rdata_out, 32'hA5);

    // T4: disjoint read and write in one cycle
    cyc();
    req_ren = 2'b01; req_raddr[4:0] = 5'd2;
    req_wen = 2'b10; req_waddr[9:5] = 5'd9; req_wdata[63:32] = 32'h99;
    #1;
    check("t4_rgnt", rgnt, 2'b01);
    check("t4_wgnt", wgnt, 2'b10);
    check("t4_raddr", ram_raddr, 2);
    check("t4_waddr", ram_waddr, 9);
    cyc(); idle(); #1;
    check("t4_stall", stall_cnt, 1);
    check("t4_rvalid", rvalid, 2'b01);
    check("t4_rdata", rdata_out, 0);

    // T5: reset kills a pending read and clears pointers
    cyc();
    req_wen = 2'b01; req_waddr[4:0] = 5'd12; req_wdata[31:0] = 32'h12;
    cyc();
    req_wen = '0; req_ren = 2'b01; req_raddr[4:0] = 5'd2;
    #1;
    check("t5_rgnt", rgnt, 2'b01);
    rst = 1'b0;
    #1;
    check("t5_rgnt_rst", rgnt, 0);
    check("t5_rv_rst", rvalid, 0);
    cyc();
    check("t5_rv_hold", rvalid, 0);
    idle(); rst = 1'b1;
    cyc();
    req_ren = 2'b11; req_raddr = {5'd2, 5'd1};
    req_wen = 2'b11; req_waddr = {5'd11, 5'd10};
    #1;
    check("t5_rptr0", rgnt, 2'b01);
    check("t5_wptr0", wgnt, 2'b01);
    check("t5_rv_none", rvalid, 0);
    check("t5_stall", stall_cnt, 0);
    cyc(); idle(); #1;
    check("t5_rvalid", rvalid, 2'b01);

    // T6: persistent hazard saturates the counter
    cyc();
    req_wen = 2'b01; req_waddr[4:0] = 5'd5; req_wdata[31:0] = 32'h55;
    req_ren = 2'b10; req_raddr[9:5] = 5'd5;
    #1;
    check("t6_rgnt0", rgnt, 0);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      check($sformatf("t6_stall%0d", k), stall_cnt, (k < 7) ? k : 7);
      check($sformatf("t6_rgnt%0d", k), rgnt, 0);
    end
    req_wen = '0;
    #1;
    check("t6_rgnt_go", rgnt, 2'b10);
    cyc(); idle(); #1;
    check("t6_rvalid", rvalid, 2'b10);
    check("t6_rdata", rdata_out, 32'h55);
    check("t6_sat", stall_cnt, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
